inv_mix_columns_iter: RTL

Iterative AES InvMixColumns engine for the decryption datapath; the inverse of the combinational MixColumns block.
- Accepts one 128-bit state through a valid/ready handshake.
- Transforms COLS_PER_CYCLE columns per clock.
- Holds the result until downstream accepts it.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the decryption round loop.

---
 rtl/aes_pkg.sv | 41 ++++
 rtl/inv_mix_single_column.sv | 24 ++
 rtl/inv_mix_columns_iter.sv | 94 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) arithmetic helpers for the round datapath.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_COL_W   = 32;
  localparam int unsigned AES_NCOLS   = AES_STATE_W / AES_COL_W;

  localparam logic [7:0] INV_MC_C0 = 8'h0e;
  localparam logic [7:0] INV_MC_C1 = 8'h0b;
  localparam logic [7:0] INV_MC_C2 = 8'h0d;
  localparam logic [7:0] INV_MC_C3 = 8'h09;

  localparam logic [7:0] MC_C0 = 8'h02;
  localparam logic [7:0] MC_C1 = 8'h03;
  localparam logic [7:0] MC_C2 = 8'h01;
  localparam logic [7:0] MC_C3 = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } inv_mc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; constant operands fold down to a few XORs.
  function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// Combinational InvMixColumns of one 32-bit column; MSB byte is row 0.
module inv_mix_single_column
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_i,
  output logic [AES_COL_W-1:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  function automatic logic [7:0] inv_row(input logic [7:0] x0, input logic [7:0] x1,
                                         input logic [7:0] x2, input logic [7:0] x3);
    return gf_mul8(INV_MC_C0, x0) ^ gf_mul8(INV_MC_C1, x1) ^
           gf_mul8(INV_MC_C2, x2) ^ gf_mul8(INV_MC_C3, x3);
  endfunction

  assign {a0, a1, a2, a3} = col_i;

  assign col_o = {inv_row(a0, a1, a2, a3),
                  inv_row(a1, a2, a3, a0),
                  inv_row(a2, a3, a0, a1),
                  inv_row(a3, a0, a1, a2)};

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative InvMixColumns: COLS_PER_CYCLE columns per clock, result held until accepted.
module inv_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [AES_STATE_W-1:0] iData,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [AES_STATE_W-1:0] oData
);

  localparam int unsigned NCYC  = AES_NCOLS / COLS_PER_CYCLE;
  localparam int unsigned CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  inv_mc_state_e                         fsm_q;
  logic [AES_NCOLS-1:0][AES_COL_W-1:0]   state_q;
  logic [AES_NCOLS-1:0][AES_COL_W-1:0]   state_d;
  logic [CNT_W-1:0]                      cnt_q;
  logic [AES_COL_W-1:0]                  lane_in  [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0]                  lane_out [COLS_PER_CYCLE];

  // Column c lives at state_q[3-c]; ~sel maps a 2-bit column index to that slot.
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
    logic [1:0] col_sel;
    assign col_sel    = 2'(32'(cnt_q) * COLS_PER_CYCLE + k);
    assign lane_in[k] = state_q[~col_sel];

    inv_mix_single_column u_col (
      .col_i (lane_in[k]),
      .col_o (lane_out[k])
    );
  end

  for (genvar c = 0; c < AES_NCOLS; c++) begin : g_col
    assign state_d[3-c] = (CNT_W'(c / COLS_PER_CYCLE) == cnt_q) ? lane_out[c % COLS_PER_CYCLE]
                                                                 : state_q[3-c];
  end

  assign oReady = (fsm_q == ST_IDLE) | ((fsm_q == ST_DONE) & iReady);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      fsm_q   <= ST_IDLE;
      oValid  <= 1'b0;
      oData   <= '0;
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (iValid) begin
            state_q <= iData;
            cnt_q   <= '0;
            fsm_q   <= ST_CALC;
          end
        end
        ST_CALC: begin
          state_q <= state_d;
          if (cnt_q == CNT_W'(NCYC - 1)) begin
            cnt_q  <= '0;
            oData  <= state_d;
            oValid <= 1'b1;
            fsm_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (iReady) begin
            oValid <= 1'b0;
            if (iValid) begin
              state_q <= iData;
              cnt_q   <= '0;
              fsm_q   <= ST_CALC;
            end else begin
              fsm_q <= ST_IDLE;
            end
          end
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

endmodule
